bin_pixel_packer: RTL and testbench

Packs the thresholded 1-bit pixel stream from the Bayer/threshold stage into bytes of 8 horizontally adjacent pixels and presents them, with a write strobe, to the SDRAM write-FIFO port. It sits between RAW2RGB and Sdram_Control_4Port and replaces the free-running shift register and divided write clock. Every byte write is frame-aligned and counted, and a frame-done pulse is raised for the HPS handshake.

---
 rtl/bin_pixel_packer_pkg.sv | 19 +
 rtl/pack_shift8.sv | 57 +++++
 rtl/bin_pixel_packer.sv | 133 +++++++++++++
 tb/tb_bin_pixel_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_pixel_packer_pkg.sv
// Purpose : shared states and widths for the binary pixel packer.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package bin_pixel_packer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ACTIVE,
        FLUSH,
        DONE
    } state_t;

    localparam int PIX_PER_BYTE = 8;
    localparam int PCNT_W       = 19;
    localparam int ADDR_W       = 16;
    localparam int ONES_W       = 20;

endpackage

// File: rtl/pack_shift8.sv
// Purpose : 8-pixel accumulator with bit counter; presents a full or flushed byte.
// Latency : combinational byte out in the cycle the 8th pixel shifts or flush is asserted.
// Backpressure : none; the consumer must take byte/byte_valid in that same cycle.
//
// Ports: clk, rst (sync, active high); clear restarts the byte (may coincide
// with shift, the shifted pixel then becomes bit 0 of a fresh byte); shift
// accepts pixel; flush emits the partial byte left-aligned and zero padded.
// Outputs: packed_byte, byte_valid, partial (bit counter non-zero).
module pack_shift8
    import bin_pixel_packer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift,
    input  logic       flush,
    input  logic       pixel,
    output logic [7:0] packed_byte,
    output logic       byte_valid,
    output logic       partial
);

    logic [7:0] acc;
    logic [2:0] bcnt;
    logic [2:0] bcnt_eff;
    logic [7:0] shifted;
    logic [3:0] pad;

    // A clear in the same cycle as a shift starts the byte from scratch.
    assign bcnt_eff = clear ? 3'd0 : bcnt;
    assign shifted  = clear ? {7'd0, pixel} : {acc[6:0], pixel};
    assign pad      = 4'd8 - {1'b0, bcnt};
    assign partial  = (bcnt != 3'd0);

    always_comb begin
        packed_byte = shifted;
        byte_valid  = shift && (bcnt_eff == 3'(PIX_PER_BYTE - 1));
        if (flush) begin
            packed_byte = acc << pad;
            byte_valid  = partial;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= 8'd0;
            bcnt <= 3'd0;
        end else if (flush || (clear && !shift)) begin
            acc  <= 8'd0;
            bcnt <= 3'd0;
        end else if (shift) begin
            acc  <= shifted;
            bcnt <= bcnt_eff + 3'd1;   // wraps 7 -> 0 at each full byte
        end
    end

endmodule

// File: rtl/bin_pixel_packer.sv
// Purpose : frame-aligned packing of 1-bit pixels into bytes for the SDRAM write FIFO.
// Latency : oWR one cycle after the 8th accepted pixel; flush write two cycles after iFVAL falls.
// Backpressure : none; the FIFO must accept every oWR strobe (at most 1 per 8 pixels).
//
// Ports: iCLK, iRST (sync, active high), iEN arms the next whole frame,
// iFVAL/iDVAL/iPIXEL pixel stream; oDATA {zeros, byte} with first pixel in
// bit 7, oWR strobe, oBYTE_ADDR byte index, oBUSY, oFRAME_DONE pulse,
// oOVF sticky overflow, oONES_CNT count of 1-pixels in the last frame.
// Optional feature: define BIN_PIXEL_PACKER_ONES_CNT_EN to build the ones
// counter; otherwise oONES_CNT is tied to zero.
module bin_pixel_packer
    import bin_pixel_packer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic              iPIXEL,
    output logic [DATA_W-1:0] oDATA,
    output logic              oWR,
    output logic [15:0]       oBYTE_ADDR,
    output logic              oBUSY,
    output logic              oFRAME_DONE,
    output logic              oOVF,
    output logic [19:0]       oONES_CNT
);

    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(H_ACTIVE * V_ACTIVE);

    state_t            state, state_nxt;
    logic [PCNT_W-1:0] pcnt;
    logic [ADDR_W-1:0] byte_idx;
    logic              start, in_frame, pix_full, accept, drop;
    logic [7:0]        packed_byte;
    logic              byte_valid, partial;

    // start is the ARMED->ACTIVE cycle; its pixel already belongs to the frame.
    assign start    = (state == ARMED) && iEN && iFVAL;
    assign in_frame = (state == ACTIVE) && iFVAL;
    assign pix_full = (pcnt == PCNT_MAX);
    assign accept   = iDVAL && (start || (in_frame && !pix_full));
    assign drop     = in_frame && iDVAL && pix_full;
    assign oBUSY    = (state == ARMED) || (state == ACTIVE) || (state == FLUSH);

    pack_shift8 u_shift (
        .clk         (iCLK),
        .rst         (iRST),
        .clear       (start),
        .shift       (accept),
        .flush       (state == FLUSH),
        .pixel       (iPIXEL),
        .packed_byte (packed_byte),
        .byte_valid  (byte_valid),
        .partial     (partial)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (iEN && !iFVAL) state_nxt = ARMED;
            ARMED:  if (!iEN) state_nxt = IDLE;
                    else if (iFVAL) state_nxt = ACTIVE;
            ACTIVE: if (!iFVAL) state_nxt = partial ? FLUSH : DONE;
            FLUSH:  state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            pcnt        <= '0;
            byte_idx    <= '0;
            oDATA       <= '0;
            oWR         <= 1'b0;
            oBYTE_ADDR  <= '0;
            oFRAME_DONE <= 1'b0;
            oOVF        <= 1'b0;
        end else begin
            state       <= state_nxt;
            oWR         <= byte_valid;
            oFRAME_DONE <= (state == DONE);

            // pcnt stops at PCNT_MAX because accept is blocked there.
            if (start)
                pcnt <= PCNT_W'(accept);
            else if (accept)
                pcnt <= pcnt + PCNT_W'(1);

            if (start)
                oOVF <= 1'b0;
            else if (drop)
                oOVF <= 1'b1;

            if (start)
                byte_idx <= '0;
            else if (byte_valid && (byte_idx != '1))
                byte_idx <= byte_idx + ADDR_W'(1);

            if (byte_valid) begin
                oDATA      <= DATA_W'(packed_byte);
                oBYTE_ADDR <= byte_idx;
            end
        end
    end

`ifdef BIN_PIXEL_PACKER_ONES_CNT_EN
    logic [ONES_W-1:0] ones_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ones_cnt  <= '0;
            oONES_CNT <= '0;
        end else begin
            if (start)
                ones_cnt <= ONES_W'(accept && iPIXEL);
            else if (accept && iPIXEL)
                ones_cnt <= ones_cnt + ONES_W'(1);
            if (state == DONE)
                oONES_CNT <= ones_cnt;
        end
    end
`else
    assign oONES_CNT = '0;
`endif

endmodule

// File: tb/tb_bin_pixel_packer.sv
// Purpose : directed self-checking bench for bin_pixel_packer (16x2 frame).
// Latency : n/a.
// Backpressure : n/a.
module tb_bin_pixel_packer;

`ifdef BIN_PIXEL_PACKER_ONES_CNT_EN
    localparam bit ONES_ON = 1'b1;
`else
    localparam bit ONES_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, fval, dval, pix;
    logic [15:0] data;
    logic        wr;
    logic [15:0] addr;
    logic        busy, done, ovf;
    logic [19:0] ones;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] wdat[$];
    logic [15:0] wadr[$];
    int          wcyc[$];
    int          dcyc[$];

    bin_pixel_packer #(.H_ACTIVE(16), .V_ACTIVE(2), .DATA_W(16)) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iEN         (en),
        .iFVAL       (fval),
        .iDVAL       (dval),
        .iPIXEL      (pix),
        .oDATA       (data),
        .oWR         (wr),
        .oBYTE_ADDR  (addr),
        .oBUSY       (busy),
        .oFRAME_DONE (done),
        .oOVF        (ovf),
        .oONES_CNT   (ones)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // cyc seen here equals the number of the edge whose registered outputs are on view.
    always @(negedge clk) begin
        if (wr) begin
            wdat.push_back(data);
            wadr.push_back(addr);
            wcyc.push_back(cyc);
        end
        if (done) dcyc.push_back(cyc);
    end

    // Inputs are applied, then sampled at the next edge; afterwards cyc is that edge's number.
    task automatic drive(input logic f, input logic d, input logic p);
        fval = f; dval = d; pix = p;
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        wdat.delete(); wadr.delete(); wcyc.delete(); dcyc.delete();
    endtask

    task automatic arm();
        en = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        checks++; if (data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", data); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", wr); end
        checks++; if (addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (ones !== 20'h0) begin errors++; $display("FAIL reset_ones got %0d want 0", ones); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_frame();
        int e[4];
        int f;
        clear_mon();
        arm();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL armed_busy got %b want 1", busy); end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 0));
            if (i % 8 == 7) e[i / 8] = cyc;
        end
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        f = cyc;
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        checks++; if (wdat.size() !== 4) begin errors++; $display("FAIL full_wr_count got %0d want 4", wdat.size()); end
        for (int i = 0; i < 4 && i < wdat.size(); i++) begin
            checks++; if (wdat[i] !== 16'h00AA) begin errors++; $display("FAIL full_data[%0d] got %h want 00aa", i, wdat[i]); end
            checks++; if (wadr[i] !== 16'(i)) begin errors++; $display("FAIL full_addr[%0d] got %0d want %0d", i, wadr[i], i); end
            checks++; if (wcyc[i] !== e[i]) begin errors++; $display("FAIL full_lat[%0d] got cyc %0d want %0d", i, wcyc[i], e[i]); end
        end
        checks++; if (dcyc.size() !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", dcyc.size()); end
        if (dcyc.size() > 0) begin
            checks++; if (dcyc[0] !== f + 1) begin errors++; $display("FAIL full_done_time got cyc %0d want %0d", dcyc[0], f + 1); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf got %b want 0", ovf); end
        checks++; if (ones !== (ONES_ON ? 20'd16 : 20'd0)) begin errors++; $display("FAIL full_ones got %0d want %0d", ones, ONES_ON ? 16 : 0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_bit_order();
        logic [7:0] bits;
        int e8;
        int f;
        bits = 8'b1000_0001;
        clear_mon();
        arm();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, bits[7 - i]);
            if (i == 7) e8 = cyc;
            drive(1'b1, 1'b0, 1'b1);
            drive(1'b1, 1'b0, 1'b1);
        end
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        f = cyc;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        checks++; if (wdat.size() !== 1) begin errors++; $display("FAIL order_wr_count got %0d want 1", wdat.size()); end
        if (wdat.size() > 0) begin
            checks++; if (wdat[0] !== 16'h0081) begin errors++; $display("FAIL order_data got %h want 0081", wdat[0]); end
            checks++; if (wadr[0] !== 16'h0) begin errors++; $display("FAIL order_addr got %0d want 0", wadr[0]); end
            checks++; if (wcyc[0] !== e8) begin errors++; $display("FAIL order_lat got cyc %0d want %0d", wcyc[0], e8); end
        end
        if (dcyc.size() > 0) begin
            checks++; if (dcyc[0] !== f + 1) begin errors++; $display("FAIL order_done_time got cyc %0d want %0d", dcyc[0], f + 1); end
        end else begin
            checks++; errors++; $display("FAIL order_done_count got 0 want 1");
        end
    endtask

    task automatic test_short_frame();
        int e0;
        int f;
        clear_mon();
        arm();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            if (i == 7) e0 = cyc;
        end
        en = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        f = cyc;
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        checks++; if (wdat.size() !== 2) begin errors++; $display("FAIL short_wr_count got %0d want 2", wdat.size()); end
        if (wdat.size() == 2) begin
            checks++; if (wdat[0] !== 16'h00FF) begin errors++; $display("FAIL short_data0 got %h want 00ff", wdat[0]); end
            checks++; if (wcyc[0] !== e0) begin errors++; $display("FAIL short_lat0 got cyc %0d want %0d", wcyc[0], e0); end
            checks++; if (wdat[1] !== 16'h00E0) begin errors++; $display("FAIL short_flush_data got %h want 00e0", wdat[1]); end
            checks++; if (wadr[1] !== 16'h1) begin errors++; $display("FAIL short_flush_addr got %0d want 1", wadr[1]); end
            checks++; if (wcyc[1] !== f + 1) begin errors++; $display("FAIL short_flush_time got cyc %0d want %0d", wcyc[1], f + 1); end
        end
        if (dcyc.size() > 0) begin
            checks++; if (dcyc[0] !== f + 2) begin errors++; $display("FAIL short_done_time got cyc %0d want %0d", dcyc[0], f + 2); end
        end else begin
            checks++; errors++; $display("FAIL short_done_count got 0 want 1");
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL short_ovf got %b want 0", ovf); end
        checks++; if (ones !== (ONES_ON ? 20'd11 : 20'd0)) begin errors++; $display("FAIL short_ones got %0d want %0d", ones, ONES_ON ? 11 : 0); end
    endtask

    task automatic test_overflow_midarm();
        int f;
        clear_mon();
        en = 1'b1;
        // Frame already running when iEN rises: must be ignored.
        repeat (16) drive(1'b1, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midarm_busy got %b want 0", busy); end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, (i >= 32) || (i % 2 == 0));
            if (i == 31) begin
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_limit got %b want 0", ovf); end
            end
            if (i == 32) begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_past_limit got %b want 1", ovf); end
            end
        end
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        f = cyc;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        checks++; if (wdat.size() !== 4) begin errors++; $display("FAIL ovf_wr_count got %0d want 4", wdat.size()); end
        for (int i = 0; i < 4 && i < wdat.size(); i++) begin
            checks++; if (wdat[i] !== 16'h00AA) begin errors++; $display("FAIL ovf_data[%0d] got %h want 00aa", i, wdat[i]); end
        end
        checks++; if (addr !== 16'h3) begin errors++; $display("FAIL ovf_last_addr got %0d want 3", addr); end
        if (dcyc.size() > 0) begin
            checks++; if (dcyc[0] !== f + 1) begin errors++; $display("FAIL ovf_done_time got cyc %0d want %0d", dcyc[0], f + 1); end
        end else begin
            checks++; errors++; $display("FAIL ovf_done_count got 0 want 1");
        end
        checks++; if (ones !== (ONES_ON ? 20'd16 : 20'd0)) begin errors++; $display("FAIL ovf_ones got %0d want %0d", ones, ONES_ON ? 16 : 0); end
        arm();
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ones_count();
        clear_mon();
        arm();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, (i < 13));
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        checks++; if (wdat.size() !== 2) begin errors++; $display("FAIL ones_wr_count got %0d want 2", wdat.size()); end
        if (wdat.size() == 2) begin
            checks++; if (wdat[1] !== 16'h00F8) begin errors++; $display("FAIL ones_data1 got %h want 00f8", wdat[1]); end
        end
        checks++; if (ones !== (ONES_ON ? 20'd13 : 20'd0)) begin errors++; $display("FAIL ones_cnt got %0d want %0d", ones, ONES_ON ? 13 : 0); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        arm();
        repeat (5) drive(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        checks++; if (data !== 16'h0) begin errors++; $display("FAIL rstmid_data got %h want 0000", data); end
        checks++; if (addr !== 16'h0) begin errors++; $display("FAIL rstmid_addr got %h want 0000", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (ones !== 20'h0) begin errors++; $display("FAIL rstmid_ones got %0d want 0", ones); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b want 0", ovf); end
        rst = 1'b0;
        // Still mid-frame after reset: the block must stay idle.
        repeat (5) drive(1'b1, 1'b1, 1'b1);
        en = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        checks++; if (wdat.size() !== 0) begin errors++; $display("FAIL rstmid_wr_count got %0d want 0", wdat.size()); end
        checks++; if (dcyc.size() !== 0) begin errors++; $display("FAIL rstmid_done_count got %0d want 0", dcyc.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fval = 1'b0; dval = 1'b0; pix = 1'b0;
        test_reset();
        test_full_frame();
        test_bit_order();
        test_short_frame();
        test_overflow_midarm();
        test_ones_count();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
